mux_rr_generic: RTL and testbench
=================================

# mux_rr_generic

Registered, parametrised N:1 multiplexer with per-channel valid/ready handshakes. It selects among 2^SEL channels of BUS_WIDTH bits each, either by a fixed select (`ctrl_sel`) or by fair round-robin arbitration. The selected word lands in a single output register with backpressure. It is the sequential successor to the combinational generic mux. It sits where several producers share one downstream consumer.

## Interface
- `BUS_WIDTH`, default 2: data width per channel, ≥1.
- `SEL`, default 5: select width; channel count N = 2^SEL, SEL ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `data_in` input BUS_WIDTH*N: flattened channel data; channel i occupies bits [BUS_WIDTH*i +: BUS_WIDTH].
- `in_valid` input N: per-channel request.
- `in_ready` output N: per-channel accept; combinational.
- `ctrl_sel` input SEL: channel to serve when `rr_en`=0.
- `rr_en` input 1: 1 = round-robin, 0 = fixed select.
- `data_out` output BUS_WIDTH: registered selected word.
- `out_valid` output 1: `data_out` holds an unconsumed word.
- `out_ready` input 1: downstream accepts `data_out`.
- `out_sel` output SEL: channel index that `data_out` came from.

## Operation
- `load_en` = !out_valid || out_ready. This allows full throughput of one word per cycle.
- **Fixed mode** (`rr_en`=0): the candidate is `ctrl_sel`. The grant is valid iff `in_valid[ctrl_sel]`.
- **Round-robin mode** (`rr_en`=1):
  - The grant is the first i with `in_valid[i]`=1, searching from (last_grant+1) mod N upward.
  - The search wraps from N-1 to 0 and covers all N channels.
  - There is no grant if `in_valid`=0.
- `in_ready[g]` = load_en && grant_valid, for the granted g only. All other bits are 0.
- A transfer occurs when `in_valid[g]` && `in_ready[g]`. On that clock edge:
  - `data_out` ← slice g.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - `last_grant` ← g. This update happens in both modes.
- If load_en and there is no grant: `out_valid` ← 0. `data_out` and `out_sel` hold their previous values.
- If !load_en (stall): all registers hold and `in_ready` = 0.
- `rr_en` or `ctrl_sel` changes affect only the next grant decision. A word already held is never altered.
- There is no handshake with a pending word: the grant is recomputed every cycle. A requester may drop `in_valid` before being granted without side effects.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low, no clock needed):
  - `out_valid`=0, `data_out`=0, `out_sel`=0.
  - Internal `last_grant`=N-1, so the first round-robin search starts at channel 0.
  - `in_ready`=0 while in reset.
- Reset mid-operation discards the held word. Deassertion is synchronised by the integrating design.
- Latency: an input handshake in cycle t gives `out_valid`=1 with that data in cycle t+1.
- Throughput: one word per cycle when `out_ready` is held at 1.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `rr_en`, `ctrl_sel` and `last_grant`. There is no combinational path from `data_in` to any output.
- Simultaneous pop and push (`out_valid` && `out_ready` with a grant) replaces the word in the same edge, with no bubble.
- Round-robin fairness: with all N channels requesting continuously and no stalls, each channel is granted exactly once per N consecutive grants.

## Test plan
All scenarios use BUS_WIDTH=2, SEL=5.
- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1, between clock edges → `out_valid`=0, `data_out`=2'b00, `out_sel`=0 and all `in_ready`=0 immediately. Release, all `in_valid`=1, `rr_en`=1 → first grant is channel 0.
- **Fixed mode:** `rr_en`=0, `ctrl_sel`=5, `in_valid`=all 1s, ch5 data=2'b10, `out_ready`=1 → only `in_ready[5]`=1. Next cycle `data_out`=2'b10, `out_sel`=5. Channel 7 is never readied.
- **Round-robin:** `rr_en`=1, `in_valid` bits {3,17,31} held, `out_ready`=1 → grants 3,17,31,3,17 on consecutive cycles. `out_sel` shows the same sequence one cycle later.
- **Wrap-around:** after grant 31, only channels 0 and 31 valid → next grant 0, then 31, alternating.
- **Backpressure:** `out_valid`=1, `out_ready`=0 for 4 cycles with requests pending → `data_out` and `out_sel` stable and `in_ready`=0 throughout. Raise `out_ready` → new word appears one cycle later, with no lost or duplicated words.
- **Empty/mode switch:**
  - Drop all `in_valid` with `out_ready`=1 → `out_valid`=0 next cycle, `data_out` holds its value.
  - Switch `rr_en` 1→0 while stalled → held word unchanged. After the stall, the grant follows `ctrl_sel`.

Source files
------------

// File: rtl/mux_rr_generic.sv
// Registered N:1 multiplexer with per-channel valid/ready handshakes.
// The served channel comes either from a fixed select or from a fair
// round-robin arbiter. The chosen word is held in one output register
// that honours downstream backpressure.
module mux_rr_generic #(
  parameter int unsigned BUS_WIDTH = 2,
  parameter int unsigned SEL       = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [BUS_WIDTH*(2**SEL)-1:0]    data_in,
  input  logic [(2**SEL)-1:0]              in_valid,
  output logic [(2**SEL)-1:0]              in_ready,
  input  logic [SEL-1:0]                   ctrl_sel,
  input  logic                             rr_en,
  output logic [BUS_WIDTH-1:0]             data_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SEL-1:0]                   out_sel
);

  localparam int unsigned N = 2**SEL;

  logic [BUS_WIDTH-1:0] chan [N];
  logic [SEL-1:0]       last_grant;
  logic [SEL-1:0]       rr_idx;
  logic [SEL-1:0]       grant_c;
  logic                 grant_valid_c;
  logic                 load_en_c;

  // The output register can take a new word when it is empty or being drained.
  assign load_en_c = !out_valid || out_ready;

  // Split the flattened input bus into one word per channel.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      chan[i] = data_in[BUS_WIDTH*i +: BUS_WIDTH];
    end
  end

  // Grant decision: fixed select, or first requester after last_grant (wrapping).
  // Offset N wraps back onto last_grant itself, so all N channels are searched.
  always_comb begin
    grant_c       = '0;
    grant_valid_c = 1'b0;
    rr_idx        = '0;
    if (!rr_en) begin
      grant_c       = ctrl_sel;
      grant_valid_c = in_valid[ctrl_sel];
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        rr_idx = last_grant + SEL'(k);
        if (!grant_valid_c && in_valid[rr_idx]) begin
          grant_c       = rr_idx;
          grant_valid_c = 1'b1;
        end
      end
    end
  end

  // One-hot accept for the granted channel only; forced low while in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en_c && grant_valid_c) begin
      in_ready[grant_c] = 1'b1;
    end
  end

  // Output register and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      out_sel    <= '0;
      out_valid  <= 1'b0;
      last_grant <= '1;
    end else if (load_en_c) begin
      if (grant_valid_c) begin
        data_out   <= chan[grant_c];
        out_sel    <= grant_c;
        out_valid  <= 1'b1;
        last_grant <= grant_c;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_generic.sv
// Directed, table-driven bench for mux_rr_generic with BUS_WIDTH=2, SEL=5.
module tb_mux_rr_generic;

  localparam int unsigned BW = 2;
  localparam int unsigned S  = 5;
  localparam int unsigned N  = 32;
  localparam int unsigned NV = 25;

  typedef struct {
    logic [N-1:0]  iv;
    logic          rr;
    logic [S-1:0]  cs;
    logic          ordy;
    logic [N-1:0]  erdy;
    logic          eov;
    logic [BW-1:0] edat;
    logic [S-1:0]  esel;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [BW*N-1:0]   data_in;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [S-1:0]      ctrl_sel;
  logic              rr_en;
  logic [BW-1:0]     data_out;
  logic              out_valid;
  logic              out_ready;
  logic [S-1:0]      out_sel;

  int total;
  int passed;
  vec_t vt [NV];

  mux_rr_generic #(.BUS_WIDTH(BW), .SEL(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_sel  (ctrl_sel),
    .rr_en     (rr_en),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
  endtask

  function automatic vec_t mk(input logic [N-1:0] iv, input logic rr, input logic [S-1:0] cs,
                              input logic ordy, input logic [N-1:0] erdy, input logic eov,
                              input logic [BW-1:0] edat, input logic [S-1:0] esel);
    vec_t v;
    v.iv = iv; v.rr = rr; v.cs = cs; v.ordy = ordy;
    v.erdy = erdy; v.eov = eov; v.edat = edat; v.esel = esel;
    return v;
  endfunction

  localparam logic [N-1:0] ALL = 32'hFFFF_FFFF;
  localparam logic [N-1:0] M3  = 32'h8002_0008;
  localparam logic [N-1:0] M0  = 32'h8000_0001;

  initial begin
    total = 0;
    passed = 0;
    // Channel i carries (i+1) mod 4: ch0=01, ch3=00, ch5=10, ch17=10, ch31=00.
    for (int i = 0; i < int'(N); i++) data_in[BW*i +: BW] = BW'(i + 1);

    vt[0]  = mk(ALL,          1'b1, 5'd0, 1'b1, 32'h0000_0001, 1'b1, 2'b01, 5'd0);
    vt[1]  = mk(M3,           1'b1, 5'd0, 1'b1, 32'h0000_0008, 1'b1, 2'b00, 5'd3);
    vt[2]  = mk(M3,           1'b1, 5'd0, 1'b1, 32'h0002_0000, 1'b1, 2'b10, 5'd17);
    vt[3]  = mk(M3,           1'b1, 5'd0, 1'b1, 32'h8000_0000, 1'b1, 2'b00, 5'd31);
    vt[4]  = mk(M3,           1'b1, 5'd0, 1'b1, 32'h0000_0008, 1'b1, 2'b00, 5'd3);
    vt[5]  = mk(M3,           1'b1, 5'd0, 1'b1, 32'h0002_0000, 1'b1, 2'b10, 5'd17);
    vt[6]  = mk(M3,           1'b1, 5'd0, 1'b1, 32'h8000_0000, 1'b1, 2'b00, 5'd31);
    vt[7]  = mk(M0,           1'b1, 5'd0, 1'b1, 32'h0000_0001, 1'b1, 2'b01, 5'd0);
    vt[8]  = mk(M0,           1'b1, 5'd0, 1'b1, 32'h8000_0000, 1'b1, 2'b00, 5'd31);
    vt[9]  = mk(M0,           1'b1, 5'd0, 1'b1, 32'h0000_0001, 1'b1, 2'b01, 5'd0);
    vt[10] = mk(M0,           1'b1, 5'd0, 1'b1, 32'h8000_0000, 1'b1, 2'b00, 5'd31);
    vt[11] = mk(ALL,          1'b0, 5'd5, 1'b1, 32'h0000_0020, 1'b1, 2'b10, 5'd5);
    vt[12] = mk(32'hFFFF_FF7F,1'b0, 5'd7, 1'b1, 32'h0000_0000, 1'b0, 2'b10, 5'd5);
    vt[13] = mk(32'h0,        1'b1, 5'd0, 1'b1, 32'h0000_0000, 1'b0, 2'b10, 5'd5);
    vt[14] = mk(M3,           1'b1, 5'd0, 1'b1, 32'h0002_0000, 1'b1, 2'b10, 5'd17);
    vt[15] = mk(M3,           1'b1, 5'd0, 1'b0, 32'h0000_0000, 1'b1, 2'b10, 5'd17);
    vt[16] = mk(M3,           1'b1, 5'd0, 1'b0, 32'h0000_0000, 1'b1, 2'b10, 5'd17);
    vt[17] = mk(M3,           1'b0, 5'd3, 1'b0, 32'h0000_0000, 1'b1, 2'b10, 5'd17);
    vt[18] = mk(M3,           1'b0, 5'd3, 1'b0, 32'h0000_0000, 1'b1, 2'b10, 5'd17);
    vt[19] = mk(M3,           1'b0, 5'd3, 1'b1, 32'h0000_0008, 1'b1, 2'b00, 5'd3);
    vt[20] = mk(M3,           1'b1, 5'd0, 1'b1, 32'h0002_0000, 1'b1, 2'b10, 5'd17);
    vt[21] = mk(32'h0,        1'b1, 5'd0, 1'b1, 32'h0000_0000, 1'b0, 2'b10, 5'd17);
    vt[22] = mk(32'h8000_0000,1'b1, 5'd0, 1'b0, 32'h8000_0000, 1'b1, 2'b00, 5'd31);
    vt[23] = mk(32'h0000_0001,1'b1, 5'd0, 1'b0, 32'h0000_0000, 1'b1, 2'b00, 5'd31);
    vt[24] = mk(32'h0000_0001,1'b1, 5'd0, 1'b1, 32'h0000_0001, 1'b1, 2'b01, 5'd0);

    // Power-on reset with requests already present.
    rst_n = 1'b0; in_valid = ALL; rr_en = 1'b1; ctrl_sel = '0; out_ready = 1'b1;
    #2;
    chk("por_in_ready",  0, in_ready, 32'h0);
    chk("por_out_valid", 0, 32'(out_valid), 32'h0);
    chk("por_data_out",  0, 32'(data_out), 32'h0);
    chk("por_out_sel",   0, 32'(out_sel), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table: apply, check combinational accept, clock, check registered outputs.
    for (int r = 0; r < int'(NV); r++) begin
      in_valid = vt[r].iv; rr_en = vt[r].rr; ctrl_sel = vt[r].cs; out_ready = vt[r].ordy;
      #2;
      chk("in_ready", r, in_ready, vt[r].erdy);
      @(posedge clk); #1;
      chk("out_valid", r, 32'(out_valid), 32'(vt[r].eov));
      chk("data_out",  r, 32'(data_out),  32'(vt[r].edat));
      chk("out_sel",   r, 32'(out_sel),   32'(vt[r].esel));
    end

    // Asynchronous reset between edges while a word is held.
    in_valid = ALL; rr_en = 1'b1; out_ready = 1'b1;
    #2;
    chk("pre_rst_out_valid", 100, 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 100, 32'(out_valid), 32'h0);
    chk("rst_data_out",  100, 32'(data_out), 32'h0);
    chk("rst_out_sel",   100, 32'(out_sel), 32'h0);
    chk("rst_in_ready",  100, in_ready, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_valid", 101, 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    #2;
    chk("rel_in_ready", 101, in_ready, 32'h1);
    @(posedge clk); #1;
    chk("rel_out_sel",  101, 32'(out_sel), 32'h0);
    chk("rel_data_out", 101, 32'(data_out), 32'h1);

    // Fairness: all channels requesting, grants walk 1..31 then wrap to 0.
    for (int k = 1; k <= int'(N); k++) begin
      #2;
      chk("fair_in_ready", 200 + k, in_ready, 32'h1 << (k % int'(N)));
      @(posedge clk); #1;
      chk("fair_out_sel", 200 + k, 32'(out_sel), 32'(k % int'(N)));
      chk("fair_data",    200 + k, 32'(data_out), 32'((k + 1) % 4));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
